gqa_kv_scatter_control: RTL and testbench



---
 rtl/gqa_kv_scatter_control.sv | 140 ++++++++++++++
 tb/tb_gqa_kv_scatter_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gqa_kv_scatter_control.sv
// rtl/gqa_kv_scatter_control.sv - Q/K/V handshake scatter to per-head consumers with frame alignment.
// One fork engine per stream; Q is the degenerate one-head-per-group case.

module gqa_kv_fork #(
  parameter int NUM_HEADS        = 12,
  parameter int GROUP_SIZE       = 4,
  parameter int HEAD_NUM_PACKETS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  output logic                 ready,
  output logic [NUM_HEADS-1:0] split_valid,
  input  logic [NUM_HEADS-1:0] split_ready,
  input  logic                 frame_release,
  output logic                 done,
  output logic                 finish
);
  localparam int NUM_GROUPS = NUM_HEADS / GROUP_SIZE;
  localparam int BW = (HEAD_NUM_PACKETS > 1) ? $clog2(HEAD_NUM_PACKETS) : 1;
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(HEAD_NUM_PACKETS - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NUM_GROUPS - 1);

  logic [BW-1:0]                            blk;
  logic [GW-1:0]                            grp;
  logic [GROUP_SIZE-1:0]                    sent;
  logic [GROUP_SIZE-1:0]                    lane_hs;
  logic [GROUP_SIZE-1:0][NUM_GROUPS-1:0]    lane_mat;
  logic [NUM_HEADS-1:0]                     head_ok;
  logic [NUM_HEADS-1:0]                     head_hs;
  logic                                     handshake;
  logic                                     blk_last;
  logic                                     grp_last;

  for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
    localparam int G = h / GROUP_SIZE;
    localparam int J = h % GROUP_SIZE;
    logic in_grp;
    assign in_grp         = (grp == GW'(G));
    assign split_valid[h] = valid & in_grp & ~sent[J] & ~done;
    // Heads outside the active group never hold the input back.
    assign head_ok[h]     = ~in_grp | sent[J] | split_ready[h];
    assign head_hs[h]     = split_valid[h] & split_ready[h];
    assign lane_mat[J][G] = head_hs[h];
  end

  for (genvar j = 0; j < GROUP_SIZE; j++) begin : g_lane
    assign lane_hs[j] = |lane_mat[j];
  end

  assign ready     = ~done & (&head_ok);
  assign handshake = valid & ready;
  assign blk_last  = (blk == BLK_LAST);
  assign grp_last  = (grp == GRP_LAST);
  assign finish    = handshake & blk_last & grp_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk  <= '0;
      grp  <= '0;
      sent <= '0;
      done <= 1'b0;
    end else begin
      if (handshake) begin
        sent <= '0;
        blk  <= blk_last ? '0 : blk + BW'(1);
        if (blk_last) grp <= grp_last ? '0 : grp + GW'(1);
      end else if (valid) begin
        sent <= sent | lane_hs;
      end
      done <= ~frame_release & (done | finish);
    end
  end
endmodule

module gqa_kv_scatter_control #(
  parameter int NUM_HEADS         = 12,
  parameter int GROUP_SIZE        = 4,
  parameter int TENSOR_SIZE_DIM_0 = 64,
  parameter int TENSOR_SIZE_DIM_1 = 32,
  parameter int PARALLELISM_DIM_0 = 4,
  parameter int PARALLELISM_DIM_1 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 query_valid,
  output logic                 query_ready,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 value_valid,
  output logic                 value_ready,
  output logic [NUM_HEADS-1:0] split_query_valid,
  input  logic [NUM_HEADS-1:0] split_query_ready,
  output logic [NUM_HEADS-1:0] split_key_valid,
  input  logic [NUM_HEADS-1:0] split_key_ready,
  output logic [NUM_HEADS-1:0] split_value_valid,
  input  logic [NUM_HEADS-1:0] split_value_ready,
  output logic                 frame_done
);
  localparam int HEAD_NUM_PACKETS =
    (TENSOR_SIZE_DIM_0 / NUM_HEADS / PARALLELISM_DIM_0) * (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1);

  if ((NUM_HEADS % GROUP_SIZE) != 0 ||
      (TENSOR_SIZE_DIM_0 % NUM_HEADS) != 0 ||
      ((TENSOR_SIZE_DIM_0 / NUM_HEADS) % PARALLELISM_DIM_0) != 0 ||
      (TENSOR_SIZE_DIM_1 % PARALLELISM_DIM_1) != 0) begin : g_bad_cfg
    $error("gqa_kv_scatter_control: tensor/head/group sizes must divide exactly");
  end

  logic q_done, k_done, v_done;
  logic q_fin, k_fin, v_fin;
  logic frame_release;

  // A stream counts as finished if it already is, or completes this cycle.
  assign frame_release = (q_done | q_fin) & (k_done | k_fin) & (v_done | v_fin);

  gqa_kv_fork #(.NUM_HEADS(NUM_HEADS), .GROUP_SIZE(1), .HEAD_NUM_PACKETS(HEAD_NUM_PACKETS)) u_q (
    .clk(clk), .rst(rst), .valid(query_valid), .ready(query_ready),
    .split_valid(split_query_valid), .split_ready(split_query_ready),
    .frame_release(frame_release), .done(q_done), .finish(q_fin)
  );

  gqa_kv_fork #(.NUM_HEADS(NUM_HEADS), .GROUP_SIZE(GROUP_SIZE), .HEAD_NUM_PACKETS(HEAD_NUM_PACKETS)) u_k (
    .clk(clk), .rst(rst), .valid(key_valid), .ready(key_ready),
    .split_valid(split_key_valid), .split_ready(split_key_ready),
    .frame_release(frame_release), .done(k_done), .finish(k_fin)
  );

  gqa_kv_fork #(.NUM_HEADS(NUM_HEADS), .GROUP_SIZE(GROUP_SIZE), .HEAD_NUM_PACKETS(HEAD_NUM_PACKETS)) u_v (
    .clk(clk), .rst(rst), .valid(value_valid), .ready(value_ready),
    .split_valid(split_value_valid), .split_ready(split_value_ready),
    .frame_release(frame_release), .done(v_done), .finish(v_fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= frame_release;
  end
endmodule

// File: tb/tb_gqa_kv_scatter_control.sv
// tb/tb_gqa_kv_scatter_control.sv - bench for gqa_kv_scatter_control at GQA, MQA and MHA group sizes.
// Stream index s: 0=Q, 1=K, 2=V. DUT index d: 0 GQA(2), 1 MQA(4), 2 MHA(1).

module tb_gqa_kv_scatter_control;
  localparam int HNP = 4;
  localparam int BUDGET = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       xv [3][3];
  logic       xr [3][3];
  logic [3:0] sv [3][3];
  logic [3:0] sr [3][3];
  logic       fd [3];

  int  gsz [3] = '{2, 4, 1};
  int  idx [3][3];
  bit  mdone [3][3];
  bit  msent [3][3][4];
  bit  hs_prev [3][3];
  bit  exp_fd [3];
  int  cnt [3][3][4];
  int  fdcnt [3];
  int  frames [3];
  bit  counting;
  int  checks;
  int  failures;
  int  cyc;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int GS = (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    gqa_kv_scatter_control #(
      .NUM_HEADS(4), .GROUP_SIZE(GS), .TENSOR_SIZE_DIM_0(16), .TENSOR_SIZE_DIM_1(4),
      .PARALLELISM_DIM_0(2), .PARALLELISM_DIM_1(2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .query_valid(xv[d][0]), .query_ready(xr[d][0]),
      .key_valid(xv[d][1]), .key_ready(xr[d][1]),
      .value_valid(xv[d][2]), .value_ready(xr[d][2]),
      .split_query_valid(sv[d][0]), .split_query_ready(sr[d][0]),
      .split_key_valid(sv[d][1]), .split_key_ready(sr[d][1]),
      .split_value_valid(sv[d][2]), .split_value_ready(sr[d][2]),
      .frame_done(fd[d])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int grp_size(int d, int s);
    return (s == 0) ? 1 : gsz[d];
  endfunction

  // Each head of the beat's group must see the beat exactly once.
  function automatic logic [3:0] mexp_valid(int d, int s);
    logic [3:0] r;
    int gs;
    int g;
    r  = '0;
    gs = grp_size(d, s);
    g  = idx[d][s] / HNP;
    if (!mdone[d][s])
      for (int h = 0; h < 4; h++)
        if (h / gs == g && xv[d][s] && !msent[d][s][h]) r[h] = 1'b1;
    return r;
  endfunction

  function automatic logic mexp_ready(int d, int s);
    logic r;
    int gs;
    int g;
    gs = grp_size(d, s);
    g  = idx[d][s] / HNP;
    r  = !mdone[d][s];
    for (int h = 0; h < 4; h++)
      if (h / gs == g && !(msent[d][s][h] || sr[d][s][h])) r = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      exp_fd[d] = 1'b0;
      for (int s = 0; s < 3; s++) begin
        idx[d][s] = 0;
        mdone[d][s] = 1'b0;
        hs_prev[d][s] = 1'b0;
        for (int h = 0; h < 4; h++) msent[d][s][h] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      for (int s = 0; s < 3; s++) begin
        logic r;
        logic [3:0] ev;
        r  = mexp_ready(d, s);
        ev = mexp_valid(d, s);
        hs_prev[d][s] = xv[d][s] & r;
        if (counting)
          for (int h = 0; h < 4; h++) if (sv[d][s][h] & sr[d][s][h]) cnt[d][s][h]++;
        if (xv[d][s] && r) begin
          idx[d][s]++;
          for (int h = 0; h < 4; h++) msent[d][s][h] = 1'b0;
          if (idx[d][s] == (4 / grp_size(d, s)) * HNP) begin
            idx[d][s] = 0;
            mdone[d][s] = 1'b1;
          end
        end else if (xv[d][s]) begin
          for (int h = 0; h < 4; h++) if (ev[h] & sr[d][s][h]) msent[d][s][h] = 1'b1;
        end
      end
      if (mdone[d][0] && mdone[d][1] && mdone[d][2]) begin
        for (int s = 0; s < 3; s++) mdone[d][s] = 1'b0;
        exp_fd[d] = 1'b1;
      end else begin
        exp_fd[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_frame_done", d), 32'(fd[d]), 32'(exp_fd[d]));
      if (counting && fd[d]) fdcnt[d]++;
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("d%0d_s%0d_split_valid", d, s), 32'(sv[d][s]), 32'(mexp_valid(d, s)));
        chk($sformatf("d%0d_s%0d_ready", d, s), 32'(xr[d][s]), 32'(mexp_ready(d, s)));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    if (!rst) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic v, input logic [3:0] r);
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 3; s++) begin
        xv[d][s] = v;
        sr[d][s] = r;
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    set_inputs(1'b0, 4'h0);
    step();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    for (int d = 0; d < 3; d++) begin
      if (exp_fd[d]) frames[d]++;
      for (int s = 0; s < 3; s++) begin
        if (frames[d] >= 3)                  xv[d][s] = 1'b0;
        else if (!(xv[d][s] && !hs_prev[d][s])) xv[d][s] = ($urandom_range(0, 3) != 0);
        for (int h = 0; h < 4; h++) sr[d][s][h] = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    counting = 1'b0;
    rst      = 1'b1;
    model_reset();
    set_inputs(1'b1, 4'hF);
    @(posedge clk);
    #1;
    chk("rst_q_valid", 32'(sv[0][0]), 32'h1);
    chk("rst_k_valid_gqa", 32'(sv[0][1]), 32'h3);
    chk("rst_k_valid_mqa", 32'(sv[1][1]), 32'hF);
    chk("rst_v_valid_mha", 32'(sv[2][2]), 32'h1);
    chk("rst_q_ready", 32'(xr[0][0]), 32'h1);
    chk("rst_frame_done", 32'(fd[0]), 32'h0);
    step();
    rst = 1'b0;

    // Full-throughput frame: K/V finish at beat 8 and stall until Q's 16th beat.
    for (int c = 0; c < 17; c++) begin
      set_inputs(1'b1, 4'hF);
      #1;
      chk($sformatf("full_q_c%0d", c), 32'(sv[0][0]), (c < 16) ? (32'h1 << (c / 4)) : 32'h1);
      chk($sformatf("full_k_c%0d", c), 32'(sv[0][1]),
          (c < 4 || c == 16) ? 32'h3 : ((c < 8) ? 32'hC : 32'h0));
      chk($sformatf("full_kready_c%0d", c), 32'(xr[0][1]), (c < 8 || c == 16) ? 32'h1 : 32'h0);
      chk($sformatf("full_fd_c%0d", c), 32'(fd[0]), (c == 16) ? 32'h1 : 32'h0);
      chk($sformatf("full_mqa_k_c%0d", c), 32'(sv[1][1]), (c < 4 || c == 16) ? 32'hF : 32'h0);
      chk($sformatf("full_mha_k_c%0d", c), 32'(sv[2][1]), (c < 16) ? (32'h1 << (c / 4)) : 32'h1);
      if (c == 5) begin
        chk("pin_model_q_c5", 32'(mexp_valid(0, 0)), 32'h2);
        chk("pin_model_k_c5", 32'(mexp_valid(0, 1)), 32'hC);
      end
      if (c == 10) chk("pin_model_kready_c10", 32'(mexp_ready(0, 1)), 32'h0);
      step();
    end

    // Slow lane: head 0 takes the K beat at t, head 1 only at t+3.
    do_reset();
    set_inputs(1'b0, 4'h0);
    xv[0][1] = 1'b1;
    sr[0][1] = 4'b0001;
    #1;
    chk("slow_t0_valid", 32'(sv[0][1]), 32'h3);
    chk("slow_t0_ready", 32'(xr[0][1]), 32'h0);
    step();
    sr[0][1] = 4'b0000;
    #1;
    chk("slow_t1_valid", 32'(sv[0][1]), 32'h2);
    chk("slow_t1_ready", 32'(xr[0][1]), 32'h0);
    step();
    #1;
    chk("slow_t2_valid", 32'(sv[0][1]), 32'h2);
    step();
    sr[0][1] = 4'b0010;
    #1;
    chk("slow_t3_valid", 32'(sv[0][1]), 32'h2);
    chk("slow_t3_ready", 32'(xr[0][1]), 32'h1);
    step();
    sr[0][1] = 4'b0011;
    #1;
    chk("slow_t4_valid", 32'(sv[0][1]), 32'h3);
    chk("slow_t4_ready", 32'(xr[0][1]), 32'h1);
    step();

    // Asynchronous reset mid-cycle after 5 Q beats and 3 K beats.
    do_reset();
    set_inputs(1'b0, 4'hF);
    xv[0][0] = 1'b1;
    xv[0][1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) xv[0][1] = 1'b0;
      step();
    end
    xv[0][1] = 1'b1;
    #1;
    chk("pre_arst_q_valid", 32'(sv[0][0]), 32'h2);
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_q_valid", 32'(sv[0][0]), 32'h1);
    chk("arst_k_valid", 32'(sv[0][1]), 32'h3);
    chk("arst_k_ready", 32'(xr[0][1]), 32'h1);
    chk("arst_fd", 32'(fd[0]), 32'h0);
    step();
    rst = 1'b0;
    step();
    #1;
    chk("post_arst_q_valid", 32'(sv[0][0]), 32'h1);

    // Random back-pressure, three frames per DUT.
    do_reset();
    counting = 1'b1;
    cyc = 0;
    for (int d = 0; d < 3; d++) begin
      frames[d] = 0;
      fdcnt[d]  = 0;
      for (int s = 0; s < 3; s++)
        for (int h = 0; h < 4; h++) cnt[d][s][h] = 0;
    end
    while ((frames[0] < 3 || frames[1] < 3 || frames[2] < 3) && cyc < BUDGET) begin
      drive_random();
      step();
      cyc++;
    end
    counting = 1'b0;
    chk("rand_within_budget", 32'(cyc < BUDGET), 32'h1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rand_d%0d_frames", d), 32'(fdcnt[d]), 32'd3);
      for (int s = 0; s < 3; s++)
        for (int h = 0; h < 4; h++)
          chk($sformatf("rand_d%0d_s%0d_h%0d_beats", d, s, h), 32'(cnt[d][s][h]), 32'd12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
